fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of a `fifo` primitive among `N` requesters. Each requester presents a word and a request. The arbiter grants one requester at a time, steers its data onto the FIFO write port, and returns a per-word acknowledge. It sits between peripheral producers (bus bridges, UART/SPI RX paths) and a shared FIFO instance, and it never writes into a full FIFO.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/dff.sv | 34 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter:
//   - arb_state_t : two-state arbiter FSM encoding (ARB_IDLE / ARB_GRANT)
//   - arb_idx_w() : width of a requester index, $clog2(N)
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff.sv
// dff
//   Generic register primitive.
//   Parameters: W (width), RESET ("sync" or "async"), RST_VAL (reset value).
//   Ports:
//     clk  in  1 - rising-edge clock
//     rst  in  1 - active-high reset, synchronous unless RESET == "async"
//     d    in  W - next value
//     q    out W - registered value
module dff #(
  parameter int            W       = 1,
  parameter string         RESET   = "sync",
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (RESET == "async") begin : g_async
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req upward starting at
//   last+1 (mod N) and returns the first requester found.
//   Ports:
//     req   in  N  - request vector
//     last  in  IW - index of the most recently served requester
//     pick  out N  - one-hot selected requester (0 when none)
//     idx   out IW - index of the selected requester
//     any   out 1  - at least one request is pending
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            w_cand;
  logic [IW-1:0] w_cand_idx;

  always_comb begin
    pick       = '0;
    idx        = '0;
    any        = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    // k = N wraps back to last itself, so a lone requester that was just
    // served can still be granted again.
    for (int k = 1; k <= N; k++) begin
      w_cand     = (int'(last) + k) % N;
      w_cand_idx = IW'(w_cand);
      if (!any && req[w_cand_idx]) begin
        any             = 1'b1;
        pick[w_cand_idx] = 1'b1;
        idx             = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among N requesters.
//   An IDLE cycle picks the next requester above the last one served; the
//   GRANT state then streams that requester's words into the FIFO, stalling
//   on fifo_full, until it drops req (or, with burst hold, BURST words go).
//
//   Build option: FEMTO_FIFO_ARB_BURST_EN
//     defined   - grant held for up to BURST accepted words
//     undefined - grant released after every accepted word (BURST ignored)
//
//   Ports:
//     clk        in  1        - clock, rising edge
//     rst        in  1        - synchronous active-high reset
//     req        in  N        - per-requester word-ready
//     din        in  N*WIDTH  - requester data, slice i = din[i*WIDTH +: WIDTH]
//     ack        out N        - one-hot, word on that slice written this cycle
//     grant      out N        - one-hot registered grant, 0 when idle
//     fifo_din   out WIDTH    - data to FIFO din (slice of current owner)
//     fifo_w     out 1        - FIFO write strobe
//     fifo_full  in  1        - FIFO full flag
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   din,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         grant,
  output logic [WIDTH-1:0]     fifo_din,
  output logic                 fifo_w,
  input  logic                 fifo_full
);

  localparam int IW = arb_idx_w(N);

  generate
    if (N < 2 || N > 16 || BURST < 1 || BURST > 256) begin : g_bad_param
      $error("fifo_wr_arbiter: N must be 2..16 and BURST 1..256");
    end
  endgenerate

  arb_state_t    r_state, w_state_d;
  logic [N-1:0]  r_grant, w_grant_d;
  logic [IW-1:0] r_owner, w_owner_d;
  logic [IW-1:0] r_last,  w_last_d;
  logic [N-1:0]  w_pick;
  logic [IW-1:0] w_pick_idx;
  logic          w_any;
  logic          w_burst_end;
  logic [WIDTH-1:0] w_slice [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign w_slice[i] = din[i*WIDTH +: WIDTH];
  end

  // Owner is kept across IDLE so the FIFO data bus never floats to X.
  assign fifo_din = w_slice[r_owner];
  assign grant    = r_grant;

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .idx  (w_pick_idx),
    .any  (w_any)
  );

  dff #(.W(N), .RESET("sync"), .RST_VAL('0)) u_grant_q (
    .clk(clk), .rst(rst), .d(w_grant_d), .q(r_grant)
  );

  dff #(.W(IW), .RESET("sync"), .RST_VAL('0)) u_owner_q (
    .clk(clk), .rst(rst), .d(w_owner_d), .q(r_owner)
  );

  // Reset to N-1 so requester 0 wins the first arbitration.
  dff #(.W(IW), .RESET("sync"), .RST_VAL(IW'(N-1))) u_last_q (
    .clk(clk), .rst(rst), .d(w_last_d), .q(r_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_d;
  end

`ifdef FEMTO_FIFO_ARB_BURST_EN
  localparam int CW = $clog2(BURST + 1);
  logic [CW-1:0] r_cnt, w_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_d;
  end

  // Counts accepted words only, so FIFO stalls do not eat the burst budget.
  assign w_burst_end = (r_cnt == CW'(BURST - 1));
`else
  assign w_burst_end = 1'b1;
`endif

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_owner_d = r_owner;
    w_last_d  = r_last;
    fifo_w    = 1'b0;
    ack       = '0;
`ifdef FEMTO_FIFO_ARB_BURST_EN
    w_cnt_d   = r_cnt;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_d = ARB_GRANT;
          w_grant_d = w_pick;
          w_owner_d = w_pick_idx;
`ifdef FEMTO_FIFO_ARB_BURST_EN
          w_cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        // rst gates the strobe so a reset cycle never writes the FIFO.
        fifo_w = req[r_owner] & ~fifo_full & ~rst;
        if (fifo_w) begin
          ack = r_grant;
`ifdef FEMTO_FIFO_ARB_BURST_EN
          w_cnt_d = r_cnt + 1'b1;
`endif
        end
        if (!req[r_owner] || (fifo_w && w_burst_end)) begin
          w_state_d = ARB_IDLE;
          w_grant_d = '0;
          w_last_d  = r_owner;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (N=4, WIDTH=32, BURST=4).
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge and compared with a behavioural model that tracks the
//   current owner, the last served requester and words taken in this grant.
//   Follows the FEMTO_FIFO_ARB_BURST_EN build option of the design.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int BURST = 4;
`ifdef FEMTO_FIFO_ARB_BURST_EN
  localparam int BEFF = BURST;
`else
  localparam int BEFF = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic [W-1:0]   fifo_din;
  logic           fifo_w;
  logic           fifo_full;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(N), .WIDTH(W), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .grant     (grant),
    .fifo_din  (fifo_din),
    .fifo_w    (fifo_w),
    .fifo_full (fifo_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_owner = requester holding the port (-1 when idle),
  // m_slot = requester whose data is on fifo_din, m_last = last served,
  // m_taken = words written in the current grant.
  int m_owner, m_slot, m_last, m_taken;

  logic [N-1:0] e_grant, e_ack;
  logic         e_w;
  logic [W-1:0] e_din;

  function automatic void model_reset();
    m_owner = -1;
    m_slot  = 0;
    m_last  = N - 1;
    m_taken = 0;
  endfunction

  function automatic void model_expect();
    e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e_w     = !rst && (m_owner >= 0) && req[m_owner] && !fifo_full;
    e_ack   = e_w ? e_grant : '0;
    e_din   = din[m_slot*W +: W];
  endfunction

  function automatic void model_step();
    bit wrote;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_slot  = m_owner;
          m_taken = 0;
        end
      end
    end else begin
      wrote = req[m_owner] && !fifo_full;
      if (wrote) m_taken++;
      if (!req[m_owner] || (wrote && m_taken == BEFF)) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endfunction

  task automatic cyc_in(input logic [N-1:0] r, input logic f, input logic rs);
    req       = r;
    fifo_full = f;
    rst       = rs;
    din       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic sample();
    @(negedge clk);
    model_expect();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cyc_in('1, 1'b0, 1'b1);
    sample();
    n_tests++;
    if ({grant, ack, fifo_w} !== {N'(0), N'(0), 1'b0} || fifo_din !== din[W-1:0]) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b ack=%b w=%b din=%h, want 0000 0000 0 %h",
               grant, ack, fifo_w, fifo_din, din[W-1:0]);
    end
    advance();
  endtask

  task automatic test_single();
    cyc_in('0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 4; c++) begin
      cyc_in((c < 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      din[W-1:0] = 32'h0000_00A5;
      sample();
      n_tests++;
      if ({grant, ack, fifo_w, fifo_din} !== {e_grant, e_ack, e_w, e_din}) begin
        n_fail++;
        $display("FAIL single c%0d: got g=%b a=%b w=%b d=%h want g=%b a=%b w=%b d=%h",
                 c, grant, ack, fifo_w, fifo_din, e_grant, e_ack, e_w, e_din);
      end
      if (c == 1) begin
        n_tests++;
        if ({grant, ack, fifo_w, fifo_din} !== {4'b0001, 4'b0001, 1'b1, 32'h0000_00A5}) begin
          n_fail++;
          $display("FAIL single_first_word: got g=%b a=%b w=%b d=%h want 0001 0001 1 000000a5",
                   grant, ack, fifo_w, fifo_din);
        end
      end
      if (c == 2) begin
        n_tests++;
        if ({ack, fifo_w} !== {4'b0000, 1'b0}) begin
          n_fail++;
          $display("FAIL single_idle: got a=%b w=%b want 0000 0", ack, fifo_w);
        end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] acks[$];
    logic [N-1:0] want;
    cyc_in('0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 5*(BEFF+1); c++) begin
      cyc_in('1, 1'b0, 1'b0);
      sample();
      n_tests++;
      if ({grant, ack, fifo_w, fifo_din} !== {e_grant, e_ack, e_w, e_din}) begin
        n_fail++;
        $display("FAIL round_robin c%0d: got g=%b a=%b w=%b d=%h want g=%b a=%b w=%b d=%h",
                 c, grant, ack, fifo_w, fifo_din, e_grant, e_ack, e_w, e_din);
      end
      if (fifo_w) acks.push_back(ack);
      advance();
    end
    n_tests++;
    if (acks.size() != 5*BEFF) begin
      n_fail++;
      $display("FAIL rr_word_count: got %0d want %0d", acks.size(), 5*BEFF);
    end else begin
      for (int i = 0; i < 5*BEFF; i++) begin
        want = N'(1) << ((i / BEFF) % N);
        n_tests++;
        if (acks[i] !== want) begin
          n_fail++;
          $display("FAIL rr_order word %0d: got ack=%b want %b", i, acks[i], want);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic [11:0] full_pat;
    full_pat = 12'b0000_0011_1000;  // bit c = fifo_full in cycle c
    cyc_in('0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 12; c++) begin
      cyc_in(4'b0100, full_pat[c], 1'b0);
      sample();
      n_tests++;
      if ({grant, ack, fifo_w, fifo_din} !== {e_grant, e_ack, e_w, e_din}) begin
        n_fail++;
        $display("FAIL full_stall c%0d: got g=%b a=%b w=%b d=%h want g=%b a=%b w=%b d=%h",
                 c, grant, ack, fifo_w, fifo_din, e_grant, e_ack, e_w, e_din);
      end
      if (fifo_full) begin
        n_tests++;
        if ({ack, fifo_w} !== {4'b0000, 1'b0}) begin
          n_fail++;
          $display("FAIL full_no_write c%0d: got a=%b w=%b want 0000 0", c, ack, fifo_w);
        end
      end
      advance();
    end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] r_tab [5];
    logic         f_tab [5];
    r_tab = '{4'b0010, 4'b0010, 4'b1001, 4'b1001, 4'b1001};
    f_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    cyc_in('0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 5; c++) begin
      cyc_in(r_tab[c], f_tab[c], 1'b0);
      sample();
      n_tests++;
      if ({grant, ack, fifo_w, fifo_din} !== {e_grant, e_ack, e_w, e_din}) begin
        n_fail++;
        $display("FAIL withdraw c%0d: got g=%b a=%b w=%b d=%h want g=%b a=%b w=%b d=%h",
                 c, grant, ack, fifo_w, fifo_din, e_grant, e_ack, e_w, e_din);
      end
      if (c == 2) begin
        n_tests++;
        if ({grant, fifo_w} !== {4'b0010, 1'b0}) begin
          n_fail++;
          $display("FAIL withdraw_held: got g=%b w=%b want 0010 0", grant, fifo_w);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (grant !== 4'b0000) begin
          n_fail++;
          $display("FAIL withdraw_release: got g=%b want 0000", grant);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (grant !== 4'b1000) begin
          n_fail++;
          $display("FAIL withdraw_next: got g=%b want 1000", grant);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 13; c++) begin
      cyc_in('1, 1'b0, (c == 7 || c == 8));
      sample();
      n_tests++;
      if ({grant, ack, fifo_w, fifo_din} !== {e_grant, e_ack, e_w, e_din}) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got g=%b a=%b w=%b d=%h want g=%b a=%b w=%b d=%h",
                 c, grant, ack, fifo_w, fifo_din, e_grant, e_ack, e_w, e_din);
      end
      if (c == 7 || c == 8) begin
        n_tests++;
        if ({ack, fifo_w} !== {4'b0000, 1'b0}) begin
          n_fail++;
          $display("FAIL reset_no_write c%0d: got a=%b w=%b want 0000 0", c, ack, fifo_w);
        end
      end
      if (c == 10) begin
        n_tests++;
        if ({grant, ack} !== {4'b0001, 4'b0001}) begin
          n_fail++;
          $display("FAIL reset_first_grant: got g=%b a=%b want 0001 0001", grant, ack);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc_in(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      sample();
      n_tests++;
      if ({grant, ack, fifo_w, fifo_din} !== {e_grant, e_ack, e_w, e_din}) begin
        n_fail++;
        $display("FAIL random c%0d: got g=%b a=%b w=%b d=%h want g=%b a=%b w=%b d=%h",
                 c, grant, ack, fifo_w, fifo_din, e_grant, e_ack, e_w, e_din);
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    cyc_in('0, 1'b0, 1'b1);
    advance();
    advance();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
